// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared constants for the unified memory-port arbiter of the 5-stage MIPS
// pipeline:
//   - ARB_* : arbiter state encodings (kept as plain 2-bit constants so the
//             legacy controller and debug taps can decode them directly)
//   - GRANT_IF / GRANT_DM : encoding of the last_grant register
//   - pick_dm() : the fairness rule applied when the arbiter is idle
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_BUSY_IF = 2'd1;
    localparam logic [1:0] ARB_BUSY_DM = 2'd2;
    localparam logic [1:0] ARB_DRAIN   = 2'd3;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // Data port wins a tie unless it also won the previous grant; this
    // alternation keeps fetch alive under back-to-back loads/stores.
    function automatic logic pick_dm(input logic if_pend,
                                     input logic dm_pend,
                                     input logic last_grant);
        return dm_pend && (!if_pend || (last_grant == GRANT_IF));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_watchdog
//
// Watchdog for the arbiter's memory handshake. Counts cycles spent waiting
// for mem_ack and raises a sticky error once the wait reaches TIMEOUT. The
// arbiter itself never aborts; this block only reports.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (clears counter and error)
//   clear        a new transaction was granted this cycle; restart the count
//   busy         arbiter is waiting on the memory (BUSY_IF/BUSY_DM/DRAIN)
//   ack          memory completion this cycle
//   timeout_err  sticky error, set when the wait count reaches TIMEOUT
// -----------------------------------------------------------------------------
module mem_port_arbiter_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    input  logic ack,
    output logic timeout_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT     = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST_STEP = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            timeout_err <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (busy && !ack && (count != LIMIT)) begin
            // Saturate at LIMIT; the error flag is raised on the same edge
            // the count arrives there and then stays until reset.
            count <= count + 1'b1;
            if (count == LAST_STEP) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single unified memory port between instruction fetch (IF) and
// the MEM stage (lw/sw). Each transaction is a req/ack handshake with a
// variable-latency memory: mem_req and its address/data are registered on
// grant and held until mem_ack. Results return as one-cycle done pulses with
// captured read data, and per-stage stall flags feed the pipeline controller.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/if_kill   fetch request, address, branch/jump flush
//   if_done/if_rdata         fetch completion pulse and instruction word
//   if_stall                 if_req && !if_done
//   dm_req/dm_we/dm_addr/dm_wdata   data request (we=1 store, 0 load)
//   dm_done/dm_rdata         data completion pulse and load data
//   dm_stall                 dm_req && !dm_done
//   mem_req/mem_we/mem_addr/mem_wdata   memory request, held until mem_ack
//   mem_ack/mem_rdata        memory completion pulse and read data
//   timeout_err              sticky watchdog error
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_kill,
    output logic                  if_done,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_done,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_stall,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  timeout_err
);

    logic [1:0] state;
    logic       last_grant;

    logic if_pend;
    logic dm_pend;
    logic grant_if;
    logic grant_dm;
    logic grant;
    logic waiting;

    // A requester whose done pulse is still high is masked: it is in the
    // middle of dropping its request and must not be granted again.
    // A fetch being killed is dropped without ever reaching the memory.
    assign if_pend = if_req && !if_kill && !if_done;
    assign dm_pend = dm_req && !dm_done;

    // NOTE: every signal written in this always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == ARB_IDLE) begin
            grant_dm = pick_dm(if_pend, dm_pend, last_grant);
            grant_if = if_pend && !grant_dm;
        end
    end

    assign grant   = grant_if || grant_dm;
    assign waiting = (state != ARB_IDLE);

    assign if_stall = if_req && !if_done;
    assign dm_stall = dm_req && !dm_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_IF;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            dm_done    <= 1'b0;
            dm_rdata   <= '0;
        end else begin
            // Done flags are pulses: cleared every cycle unless re-asserted.
            if_done <= 1'b0;
            dm_done <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (grant_dm) begin
                        state      <= ARB_BUSY_DM;
                        mem_req    <= 1'b1;
                        mem_we     <= dm_we;
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        last_grant <= GRANT_DM;
                    end else if (grant_if) begin
                        state      <= ARB_BUSY_IF;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        last_grant <= GRANT_IF;
                    end
                end

                ARB_BUSY_IF: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ARB_IDLE;
                        // A kill landing on the ack cycle still completes the
                        // bus transaction but the stale instruction is dropped.
                        if (!if_kill) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end
                    end else if (if_kill) begin
                        // The memory cannot be cancelled: keep mem_req up and
                        // swallow the eventual ack.
                        state <= ARB_DRAIN;
                    end
                end

                ARB_BUSY_DM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        dm_done <= 1'b1;
                        state   <= ARB_IDLE;
                        // Stores leave dm_rdata holding the last load value.
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                    end
                end

                ARB_DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ARB_IDLE;
                    end
                end

                default: begin
                    state   <= ARB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    mem_port_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .clear       (grant),
        .busy        (waiting),
        .ack         (mem_ack),
        .timeout_err (timeout_err)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. The bench plays the pipeline
// (IF and MEM requesters) and a variable-latency memory. Expected behaviour
// comes from a transaction-level model: a reference memory image, the
// alternating-priority rule expressed on "who was waiting", and the handshake
// timing rules (done exactly one cycle after ack). All sampling is on the
// falling clock edge; all driving is with blocking assignments there too.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_kill, if_done, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_done, dm_stall;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          timeout_err;

    mem_port_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_kill     (if_kill),
        .if_done     (if_done),
        .if_rdata    (if_rdata),
        .if_stall    (if_stall),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_done     (dm_done),
        .dm_rdata    (dm_rdata),
        .dm_stall    (dm_stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .timeout_err (timeout_err)
    );

    initial forever #5 clk = ~clk;

    // ---------------- bench state / reference model ----------------
    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] phys_mem [128];   // what the memory really holds
    logic [DW-1:0] ref_mem  [128];   // what the pipeline expects it to hold
    logic [DW-1:0] exp_if_rdata;
    logic [DW-1:0] exp_dm_rdata;
    logic [AW-1:0] g_addr;

    int cur;            // 0 none, 1 fetch in flight, 2 data access in flight
    bit last_dm;        // previous grant went to the data port
    bit idle_prev;      // arbiter was idle on the edge just passed
    bit pend_if, pend_dm;
    bit ack_given;
    int wait_cnt;
    int lat_force;      // fixed ack latency, or -1 for random
    bit auto_stim;
    int if_left, dm_left;
    logic [AW-1:0] if_next, dm_next;
    logic          dm_next_we;
    logic [DW-1:0] dm_next_wdata;
    int grant_log [$];
    int exp_order [5] = '{2, 1, 2, 1, 2};

    function automatic int widx(input logic [AW-1:0] a);
        return int'(a[8:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock of the pipeline + memory model, evaluated at a falling edge.
    task automatic step();
        logic e_if, e_dm;
        int   exp_g;
        e_if    = ack_given && (cur == 1);
        e_dm    = ack_given && (cur == 2);
        mem_ack = 1'b0;

        check("if_done",  32'(if_done),  32'(e_if));
        check("dm_done",  32'(dm_done),  32'(e_dm));
        check("if_stall", 32'(if_stall), 32'(if_req && !e_if));
        check("dm_stall", 32'(dm_stall), 32'(dm_req && !e_dm));

        if (e_if) begin
            exp_if_rdata = ref_mem[widx(if_addr)];
            check("if_rdata", if_rdata, exp_if_rdata);
            if_req = 1'b0;
            cur    = 0;
        end
        if (e_dm) begin
            if (dm_we) ref_mem[widx(dm_addr)] = dm_wdata;
            else       exp_dm_rdata = ref_mem[widx(dm_addr)];
            check("dm_rdata", dm_rdata, exp_dm_rdata);
            dm_req = 1'b0;
            cur    = 0;
        end
        ack_given = 1'b0;

        if (cur != 0) begin
            check("mem_req_hold",  32'(mem_req), 32'd1);
            check("mem_addr_hold", mem_addr, g_addr);
        end else if (idle_prev) begin
            if (pend_dm && (!pend_if || !last_dm)) exp_g = 2;
            else if (pend_if)                      exp_g = 1;
            else                                   exp_g = 0;
            check("mem_req_grant", 32'(mem_req), 32'(exp_g != 0));
            if (exp_g == 1) begin
                check("if_mem_addr", mem_addr, if_addr);
                check("if_mem_we",   32'(mem_we), 32'd0);
                g_addr = if_addr;
            end
            if (exp_g == 2) begin
                check("dm_mem_addr", mem_addr, dm_addr);
                check("dm_mem_we",   32'(mem_we), 32'(dm_we));
                if (dm_we) check("dm_mem_wdata", mem_wdata, dm_wdata);
                g_addr = dm_addr;
            end
            if (exp_g != 0) begin
                cur      = exp_g;
                last_dm  = (exp_g == 2);
                grant_log.push_back(exp_g);
                wait_cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            end
        end else begin
            check("mem_req_low", 32'(mem_req), 32'd0);
        end

        // Memory responder.
        mem_rdata = $urandom;
        if (cur != 0) begin
            if (wait_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = phys_mem[widx(mem_addr)];
                if (mem_we) phys_mem[widx(mem_addr)] = mem_wdata;
                ack_given = 1'b1;
            end else begin
                wait_cnt--;
            end
        end

        // Requesters: fetches live in words 0..63, data in words 64..127.
        if (!if_req && !e_if) begin
            if (auto_stim ? ($urandom_range(0, 2) == 0) : (if_left > 0)) begin
                if (auto_stim) if_addr = 32'($urandom_range(0, 63)) << 2;
                else begin
                    if_addr = if_next;
                    if_next = if_next + 32'd4;
                    if_left--;
                end
                if_req = 1'b1;
            end
        end
        if (!dm_req && !e_dm) begin
            if (auto_stim ? ($urandom_range(0, 2) == 0) : (dm_left > 0)) begin
                if (auto_stim) begin
                    dm_addr  = 32'($urandom_range(64, 127)) << 2;
                    dm_we    = 1'($urandom_range(0, 1));
                    dm_wdata = $urandom;
                end else begin
                    dm_addr  = dm_next;
                    dm_we    = dm_next_we;
                    dm_wdata = dm_next_wdata;
                    dm_next  = dm_next + 32'd4;
                    dm_left--;
                end
                dm_req = 1'b1;
            end
        end

        pend_if   = if_req;
        pend_dm   = dm_req;
        idle_prev = (cur == 0);
        @(negedge clk);
    endtask

    task automatic run_until_quiet(input int max_steps);
        int n = 0;
        while ((if_req || dm_req || cur != 0 || if_left > 0 || dm_left > 0) && n < max_steps) begin
            step();
            n++;
        end
        check("quiet_within_budget", 32'(n < max_steps), 32'd1);
    endtask

    task automatic sync_idle();
        cur       = 0;
        idle_prev = 1'b1;
        pend_if   = if_req;
        pend_dm   = dm_req;
        ack_given = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 128; i++) begin
            phys_mem[i] = $urandom;
            ref_mem[i]  = phys_mem[i];
        end
        exp_if_rdata = '0; exp_dm_rdata = '0; g_addr = '0;
        last_dm = 1'b0; lat_force = -1; auto_stim = 1'b0;
        if_left = 0; dm_left = 0; wait_cnt = 0;
        if_next = '0; dm_next = '0; dm_next_we = 1'b0; dm_next_wdata = '0;

        // ---- reset values ----
        repeat (2) @(negedge clk);
        check("rst_mem_req",   32'(mem_req), 32'd0);
        check("rst_mem_we",    32'(mem_we), 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata",  if_rdata, 32'd0);
        check("rst_dm_rdata",  dm_rdata, 32'd0);
        check("rst_dones",     32'({if_done, dm_done}), 32'd0);
        check("rst_timeout",   32'(timeout_err), 32'd0);
        rst = 1'b0;
        sync_idle();

        // ---- single fetch, ack 3 cycles after mem_req ----
        phys_mem[16] = 32'h2002_0005;
        ref_mem[16]  = 32'h2002_0005;
        lat_force = 3; if_next = 32'h40; if_left = 1;
        run_until_quiet(30);
        check("t1_if_rdata", if_rdata, 32'h2002_0005);

        // ---- store + fetch together, last grant IF -> DM first ----
        lat_force = 1;
        grant_log.delete();
        dm_next = 32'h100; dm_next_we = 1'b1; dm_next_wdata = 32'hDEAD_BEEF; dm_left = 1;
        if_next = 32'h44; if_left = 1;
        run_until_quiet(30);
        check("t2_order_len", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("t2_first",  32'(grant_log[0]), 32'd2);
            check("t2_second", 32'(grant_log[1]), 32'd1);
        end
        check("t2_store_landed", phys_mem[64], 32'hDEAD_BEEF);

        // ---- three back-to-back loads with fetch pressure ----
        lat_force = -1;
        grant_log.delete();
        dm_next = 32'h104; dm_next_we = 1'b0; dm_left = 3;
        if_next = 32'h50; if_left = 2;
        run_until_quiet(60);
        check("t3_order_len", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() == 5)
            for (int i = 0; i < 5; i++) check("t3_order", 32'(grant_log[i]), 32'(exp_order[i]));

        // ---- tie after a DM grant -> IF wins ----
        grant_log.delete();
        dm_next = 32'h120; dm_left = 1;
        if_next = 32'h58; if_left = 1;
        run_until_quiet(30);
        check("t3b_order_len", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) check("t3b_first", 32'(grant_log[0]), 32'd1);

        // ---- kill during BUSY_IF -> drain, no done ----
        if_req = 1'b1; if_addr = 32'h48;
        @(negedge clk);
        check("t4_grant", 32'(mem_req), 32'd1);
        check("t4_addr",  mem_addr, 32'h48);
        last_dm = 1'b0;
        @(negedge clk);
        if_kill = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_kill = 1'b0;
        check("t4_drain_hold", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        check("t4_req_drop", 32'(mem_req), 32'd0);
        check("t4_no_done",  32'(if_done), 32'd0);
        @(negedge clk);
        check("t4_no_done2", 32'(if_done), 32'd0);
        check("t4_rdata",    if_rdata, exp_if_rdata);

        // kill alongside an ungranted request: no grant
        if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h5C;
        @(negedge clk);
        check("t4_kill_idle", 32'(mem_req), 32'd0);
        if_req = 1'b0; if_kill = 1'b0;
        @(negedge clk);
        check("t4_kill_idle2", 32'(mem_req), 32'd0);

        // kill in the same cycle as ack
        if_req = 1'b1; if_addr = 32'h4C;
        @(negedge clk);
        check("t4_grant_b", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; if_kill = 1'b1; if_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0; if_kill = 1'b0;
        check("t4_ackkill_req",  32'(mem_req), 32'd0);
        check("t4_ackkill_done", 32'(if_done), 32'd0);
        @(negedge clk);
        check("t4_ackkill_done2", 32'(if_done), 32'd0);
        check("t4_ackkill_rdata", if_rdata, exp_if_rdata);
        sync_idle();
        lat_force = 0; if_next = 32'h60; if_left = 1;
        run_until_quiet(20);

        // ---- reset while BUSY_IF ----
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        check("t6_grant", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0;
        check("t6_mem_req",  32'(mem_req), 32'd0);
        check("t6_mem_addr", mem_addr, 32'd0);
        check("t6_mem_we",   32'(mem_we), 32'd0);
        check("t6_if_rdata", if_rdata, 32'd0);
        check("t6_dm_rdata", dm_rdata, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        check("t6_late_ack_done", 32'({if_done, dm_done}), 32'd0);
        check("t6_late_ack_req",  32'(mem_req), 32'd0);
        @(negedge clk);
        check("t6_late_ack_done2", 32'({if_done, dm_done}), 32'd0);
        check("t6_late_ack_rdata", if_rdata, 32'd0);
        exp_if_rdata = '0; exp_dm_rdata = '0; last_dm = 1'b0;
        sync_idle();
        grant_log.delete();
        lat_force = -1;
        dm_next = 32'h1F0; dm_next_we = 1'b0; dm_left = 1;
        if_next = 32'h84; if_left = 1;
        run_until_quiet(30);
        check("t6_post_rst_len", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) check("t6_post_rst_first", 32'(grant_log[0]), 32'd2);

        // ---- randomized traffic ----
        auto_stim = 1'b1;
        repeat (500) step();
        auto_stim = 1'b0;
        run_until_quiet(100);

        // ---- watchdog: 255 cycles without ack ----
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h180;
        @(negedge clk);
        check("t5_grant", 32'(mem_req), 32'd1);
        repeat (254) @(negedge clk);
        check("t5_before_limit", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("t5_at_limit", 32'(timeout_err), 32'd1);
        check("t5_still_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = phys_mem[96];
        @(negedge clk);
        mem_ack = 1'b0;
        check("t5_done",   32'(dm_done), 32'd1);
        check("t5_rdata",  dm_rdata, ref_mem[96]);
        check("t5_sticky", 32'(timeout_err), 32'd1);
        dm_req = 1'b0;
        @(negedge clk);
        check("t5_done_pulse", 32'(dm_done), 32'd0);
        check("t5_sticky2",    32'(timeout_err), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_clears", 32'(timeout_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the 5-stage MIPS pipeline.
- Sequences each transaction through a req/ack handshake with the memory, which has variable latency.
- Returns per-requester done/rdata to the pipeline.
- Drives per-stage stall flags that the pipeline controller folds into its if_en/id_en/exe_rst logic.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- TIMEOUT, 255, max cycles waiting for mem_ack before flagging an error (8-bit watchdog).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock is clk
- if_req  in  1  fetch request, held until if_done or if_kill
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_kill  in  1  branch/jump flush of the current fetch
- if_done  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched instruction
- if_stall  out  1  if_req && !if_done
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  1=store (sw), 0=load (lw)
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_done  out  1  one-cycle pulse
- dm_rdata  out  DATA_WIDTH  load data, valid with dm_done
- dm_stall  out  1  dm_req && !dm_done
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_WIDTH  address
- mem_wdata  out  DATA_WIDTH  write data
- mem_ack  in  1  one-cycle completion; mem_rdata valid that cycle
- mem_rdata  in  DATA_WIDTH  read data
- timeout_err  out  1  sticky watchdog error

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM, DRAIN.
- Reset: state IDLE. mem_req, mem_we, if_done, dm_done and timeout_err are 0. mem_addr, mem_wdata, if_rdata and dm_rdata are 0. last_grant=IF. Watchdog counter is 0.
- Reset mid-transaction: mem_req drops the next edge and the in-flight result is discarded. The memory is required to tolerate an abandoned request.
- IDLE: evaluates requests. A requester whose done pulse is high this cycle is masked, so it is not re-granted while it is still dropping req.
- Arbitration in IDLE:
  - Only dm_req pending -> BUSY_DM.
  - Only if_req pending (and !if_kill) -> BUSY_IF.
  - Both pending -> DM wins unless last_grant==DM, in which case IF wins. This alternation prevents fetch starvation under back-to-back loads/stores.
- On grant, mem_req/mem_we/mem_addr/mem_wdata are registered. mem_req is high from the cycle after the request is seen, and mem_we=0 for IF grants. last_grant is updated.
- BUSY_x: outputs hold stable until mem_ack.
  - On mem_ack: mem_req=0, rdata captured, x_done=1 the next cycle, state -> IDLE.
  - Minimum request-to-done latency is 2 cycles (request seen at t, mem_req at t+1, ack at t+1, done at t+2).
- if_kill:
  - In IDLE, or same cycle as a pending ungranted if_req: the fetch is dropped and no grant is made.
  - In BUSY_IF: state -> DRAIN. mem_req stays held until mem_ack, then -> IDLE with no if_done pulse.
  - if_kill together with mem_ack in the same cycle: transaction done, if_done suppressed, -> IDLE.
- dm_req is never killed: a MEM-stage instruction is committed.
- Stores: dm_done pulses and dm_rdata holds its previous value.
- Watchdog:
  - Counter clears on each grant and increments each BUSY/DRAIN cycle without mem_ack.
  - When the counter reaches TIMEOUT, timeout_err sets and stays set until rst.
  - The transaction keeps waiting; the arbiter does not abort.
- Stall flags are combinational from inputs and done registers. Done pulses are exactly one cycle.

Decomposition:
- Shared package / define.vh holds the state encodings (ARB_IDLE=2'd0, ARB_BUSY_IF=2'd1, ARB_BUSY_DM=2'd2, ARB_DRAIN=2'd3) and the GRANT_IF/GRANT_DM constants.
- One natural sub-module: arb_watchdog (counter + sticky error, inputs clear/busy/ack).

Test Plan:
- if_req addr 0x0000_0040, mem_ack 3 cycles after mem_req with rdata 0x2002_0005 -> mem_addr=0x40, mem_we=0, if_done one cycle after ack, if_rdata=0x2002_0005, if_stall high until done.
- dm_req we=1 addr 0x100 wdata 0xDEAD_BEEF together with if_req 0x44, last_grant=IF -> DM granted first (mem_we=1, mem_wdata=0xDEADBEEF), IF granted in the first IDLE after dm_done.
- Three back-to-back lw (dm_req re-raised right after each dm_done) with if_req held -> grant order DM, IF, DM, IF, DM; IF is never starved.
- Fetch 0x48 granted, if_kill pulsed 1 cycle before mem_ack -> state DRAIN, mem_req held until ack, no if_done, then IDLE.
- mem_ack withheld 255 cycles during BUSY_DM -> timeout_err=1 at cycle 255 and stays 1 after a later ack; rst clears it.
- rst asserted while BUSY_IF -> next cycle mem_req=0, all outputs at reset values, a late mem_ack is ignored with no done pulse.
